// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier: FSM encoding and counter sizing.
// No logic, no latency, no flow control.
package mult_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Counter must be able to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negate: o_out = i_neg ? -i_in : i_in.
// Purely combinational, zero latency, no flow control.
module cond_negate #(
    parameter int N = 8
) (
    input  logic         i_neg,
    input  logic [N-1:0] i_in,
    output logic [N-1:0] o_out
);

    assign o_out = i_neg ? (~i_in + N'(1)) : i_in;

endmodule

// File: rtl/seq_mult_n.sv
// Shift-add multiplier, one adder reused over WIDTH iterations, signed or unsigned per request.
// done pulses WIDTH+1 cycles after the accepted start; start is ignored while busy.
module seq_mult_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       r_state;
    logic             r_neg;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_product;
    logic             r_done;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_prod_fix;

    // A WIDTH-bit unsigned magnitude holds 2^(WIDTH-1), so the most-negative operand is safe.
    assign w_a_neg = signed_mode & a[WIDTH-1];
    assign w_b_neg = signed_mode & b[WIDTH-1];

    cond_negate #(.N(WIDTH)) u_mag_a (
        .i_neg (w_a_neg),
        .i_in  (a),
        .o_out (w_a_mag)
    );

    cond_negate #(.N(WIDTH)) u_mag_b (
        .i_neg (w_b_neg),
        .i_in  (b),
        .o_out (w_b_mag)
    );

    cond_negate #(.N(PW)) u_sign_fix (
        .i_neg (r_neg),
        .i_in  (r_acc),
        .o_out (w_prod_fix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= CALC;
                        r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                CALC: begin
                    // r_mcand is pre-shifted each iteration, so it always equals |a| << count.
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_product <= w_prod_fix;
                    r_done    <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign product = r_product;

endmodule
